// File: rtl/serial_stream_pkg.sv
// Shared types and width helpers for the serial stream bridge.
package serial_stream_pkg;

  typedef enum logic {
    StIdle,
    StShift
  } tx_state_e;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned chan_width(input int unsigned num_channels);
    return (num_channels <= 1) ? 1 : $clog2(num_channels);
  endfunction

  // Width of a counter that must hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_tx_lane.sv
// Transmit path: one-word load register feeding a bit shifter under a downstream ready.
module serial_tx_lane
  import serial_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  input  logic                  i_ready,
  output logic                  o_dout,
  output logic                  o_dout_valid
);

  localparam int unsigned BcntW = cnt_width(DATA_WIDTH);
  localparam logic [BcntW-1:0] BitLast = BcntW'(DATA_WIDTH - 1);

  tx_state_e r_state, w_state_next;

  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_load_full;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BcntW-1:0]      r_bit_cnt;

  logic                  w_load;
  logic                  w_src_full;
  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_adv;
  logic                  w_last_adv;
  logic                  w_take;
  logic [DATA_WIDTH-1:0] w_shift_adv;
  logic                  w_cur_bit;

  // The load register accepts regardless of i_en so the o_tx_ready handshake stays honest.
  assign w_load     = i_tx_valid & ~r_load_full;
  assign w_src_full = r_load_full | w_load;
  assign w_src_data = r_load_full ? r_load_data : i_tx_data;

  assign w_adv      = (r_state == StShift) & i_ready & i_en;
  assign w_last_adv = w_adv & (r_bit_cnt == BitLast);

  assign w_shift_adv = MSB_FIRST ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shift[DATA_WIDTH-1:1]};
  assign w_cur_bit   = MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0];

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_en && w_src_full) begin
          w_take       = 1'b1;
          w_state_next = StShift;
        end
      end
      StShift: begin
        if (w_last_adv) begin
          if (w_src_full) begin
            w_take = 1'b1;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load_data <= '0;
      r_load_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
    end else begin
      if (w_take) begin
        r_shift   <= w_src_data;
        r_bit_cnt <= '0;
      end else if (w_adv) begin
        r_shift   <= w_shift_adv;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      // An incoming word taken straight into the shifter never occupies the load register.
      if (w_take && r_load_full) begin
        r_load_full <= 1'b0;
      end else if (w_load && !w_take) begin
        r_load_full <= 1'b1;
        r_load_data <= i_tx_data;
      end
    end
  end

  assign o_tx_ready   = ~r_load_full;
  assign o_dout_valid = (r_state == StShift);
  assign o_dout       = (r_state == StShift) & w_cur_bit;

endmodule

// File: rtl/serial_stream_bridge.sv
// Bit-serial bridge: receive assembly with channel tagging and double buffering,
// idle timeout on partial words, and a transmit lane.
module serial_stream_bridge
  import serial_stream_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH   = 24,
  parameter int unsigned  NUM_CHANNELS = 2,
  parameter bit           MSB_FIRST    = 1'b0,
  parameter int unsigned  IDLE_TIMEOUT = 64,
  localparam int unsigned CHAN_W       = chan_width(NUM_CHANNELS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic [CHAN_W-1:0]     o_rx_chan,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_frame_err,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic                  o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready
);

  localparam int unsigned BcntW = cnt_width(DATA_WIDTH);
  localparam int unsigned IdleW = cnt_width(IDLE_TIMEOUT);
  localparam logic [BcntW-1:0]  BitFull  = BcntW'(DATA_WIDTH);
  localparam logic [BcntW-1:0]  BitLast  = BcntW'(DATA_WIDTH - 1);
  localparam logic [CHAN_W-1:0] ChanLast = CHAN_W'(NUM_CHANNELS - 1);
  localparam logic [IdleW-1:0]  IdleLast = IdleW'((IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1);
  localparam bit                IdleEn   = (IDLE_TIMEOUT != 0);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [BcntW-1:0]      r_bit_cnt;
  logic [IdleW-1:0]      r_idle_cnt;
  logic [CHAN_W-1:0]     r_chan;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [CHAN_W-1:0]     r_hold_chan;
  logic                  r_hold_valid;
  logic                  r_frame_err;

  logic                  w_shift_full;
  logic                  w_bit_acc;
  logic                  w_rx_accept;
  logic [DATA_WIDTH-1:0] w_shift_ins;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_done;
  logic                  w_move;
  logic                  w_idle_run;
  logic                  w_timeout;

  // Full means a complete word is parked in the shifter waiting for holding to free up.
  assign w_shift_full = (r_bit_cnt == BitFull);
  assign o_ready      = i_rst_n & i_en & ~(w_shift_full & r_hold_valid);
  assign w_bit_acc    = o_ready & i_din_valid;
  assign w_rx_accept  = i_en & r_hold_valid & i_rx_ready;

  assign w_shift_ins = MSB_FIRST ? {r_shift[DATA_WIDTH-2:0], i_din}
                                 : {i_din, r_shift[DATA_WIDTH-1:1]};
  assign w_word      = w_bit_acc ? w_shift_ins : r_shift;

  assign w_word_done = (w_bit_acc & (r_bit_cnt == BitLast)) | w_shift_full;
  assign w_move      = i_en & w_word_done & (~r_hold_valid | i_rx_ready);

  assign w_idle_run = i_en & ~i_din_valid & (r_bit_cnt != '0) & ~w_shift_full;
  assign w_timeout  = IdleEn & w_idle_run & (r_idle_cnt == IdleLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_idle_cnt   <= '0;
      r_chan       <= '0;
      r_hold_data  <= '0;
      r_hold_chan  <= '0;
      r_hold_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= w_timeout;

      if (w_bit_acc) begin
        r_shift <= w_shift_ins;
      end

      if (w_move || w_timeout) begin
        r_bit_cnt <= '0;
      end else if (w_bit_acc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_bit_acc || w_timeout || (r_bit_cnt == '0)) begin
        r_idle_cnt <= '0;
      end else if (w_idle_run) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end

      // A completing word replaces an accepted one on the same edge, keeping o_rx_valid high.
      if (w_move) begin
        r_hold_data  <= w_word;
        r_hold_chan  <= r_chan;
        r_hold_valid <= 1'b1;
        r_chan       <= (r_chan == ChanLast) ? '0 : r_chan + 1'b1;
      end else if (w_rx_accept) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data   = r_hold_data;
  assign o_rx_chan   = r_hold_chan;
  assign o_rx_valid  = r_hold_valid;
  assign o_frame_err = r_frame_err;

  serial_tx_lane #(
    .DATA_WIDTH(DATA_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_tx_lane (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_tx_data   (i_tx_data),
    .i_tx_valid  (i_tx_valid),
    .o_tx_ready  (o_tx_ready),
    .i_ready     (i_ready),
    .o_dout      (o_dout),
    .o_dout_valid(o_dout_valid)
  );

endmodule

// File: tb/tb_serial_stream_bridge.sv
// Directed bench for serial_stream_bridge: LSB-first instance for rx/loopback, MSB-first for tx.
module tb_serial_stream_bridge;

  localparam int unsigned DW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en;
  logic          din_tb, din_valid_tb, ready_tb, lb, go;
  logic          din, din_valid, ready;
  logic          rx_ready, tx_valid;
  logic [DW-1:0] tx_data;
  logic          ready_o, rx_valid, frame_err, tx_ready, dout, dout_valid;
  logic [DW-1:0] rx_data;
  logic [0:0]    rx_chan;

  logic          din2, din_valid2, rx_ready2, tx_valid2, ready2;
  logic [DW-1:0] tx_data2;
  logic          ready_o2, rx_valid2, frame_err2, tx_ready2, dout2, dout_valid2;
  logic [DW-1:0] rx_data2;
  logic [0:0]    rx_chan2;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  // Loopback wiring: rx takes a bit exactly when tx advances.
  assign din       = lb ? dout : din_tb;
  assign din_valid = lb ? (dout_valid & go) : din_valid_tb;
  assign ready     = lb ? (ready_o & go) : ready_tb;

  serial_stream_bridge #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(2),
    .MSB_FIRST   (1'b0),
    .IDLE_TIMEOUT(16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_din       (din),
    .i_din_valid (din_valid),
    .o_ready     (ready_o),
    .o_rx_data   (rx_data),
    .o_rx_chan   (rx_chan),
    .o_rx_valid  (rx_valid),
    .i_rx_ready  (rx_ready),
    .o_frame_err (frame_err),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_dout      (dout),
    .o_dout_valid(dout_valid),
    .i_ready     (ready)
  );

  serial_stream_bridge #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(2),
    .MSB_FIRST   (1'b1),
    .IDLE_TIMEOUT(16)
  ) dut_msb (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_din       (din2),
    .i_din_valid (din_valid2),
    .o_ready     (ready_o2),
    .o_rx_data   (rx_data2),
    .o_rx_chan   (rx_chan2),
    .o_rx_valid  (rx_valid2),
    .i_rx_ready  (rx_ready2),
    .o_frame_err (frame_err2),
    .i_tx_data   (tx_data2),
    .i_tx_valid  (tx_valid2),
    .o_tx_ready  (tx_ready2),
    .o_dout      (dout2),
    .o_dout_valid(dout_valid2),
    .i_ready     (ready2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic push_exp(input logic ch, input logic [DW-1:0] d);
    sb.push_back({7'd0, ch, d});
  endtask

  // Bits first..first+n-1 of w, LSB-first order.
  task automatic send_bits(input logic [DW-1:0] w, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      din_tb       = w[i];
      din_valid_tb = 1'b1;
      @(negedge clk);
    end
    din_valid_tb = 1'b0;
  endtask

  task automatic take_word(input string tag);
    logic [31:0] e;
    int n;
    n = 0;
    while (!rx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    if (rx_valid) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_data"}, 32'(rx_data), {8'd0, e[23:0]});
        check({tag, "_chan"}, 32'(rx_chan), {31'd0, e[24]});
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ready_o), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_chan"}, 32'(rx_chan), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic [31:0]   e;
    logic [31:0]   r32;
    logic          ch;
    int            idx, recv, ferr;

    rst_n = 1'b0; en = 1'b1; lb = 1'b0; go = 1'b0;
    din_tb = 1'b0; din_valid_tb = 1'b0; ready_tb = 1'b0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
    din2 = 1'b0; din_valid2 = 1'b0; rx_ready2 = 1'b0; tx_valid2 = 1'b0;
    ready2 = 1'b0; tx_data2 = '0;

    // Reset state of both instances.
    cyc(3);
    check_reset_values("rst");
    check("rst_msb_ready", 32'(ready_o2), 32'd0);
    check("rst_msb_rx", {7'd0, rx_valid2, rx_chan2, rx_data2}, 32'd0);
    check("rst_msb_tx", {29'd0, frame_err2, tx_ready2, dout_valid2 | dout2}, 32'd2);
    rst_n = 1'b1;
    cyc(1);
    check("rst_ready_after", 32'(ready_o), 32'd1);

    // Single word, rx latency.
    w = 24'hA5C3F1;
    push_exp(1'b0, w);
    send_bits(w, 0, 23);
    check("t1_early_valid", 32'(rx_valid), 32'd0);
    send_bits(w, 23, 1);
    check("t1_latency", 32'(rx_valid), 32'd1);
    take_word("t1");
    check("t1_released", 32'(rx_valid), 32'd0);

    // Double buffering with the datapath stalled.
    do_reset();
    push_exp(1'b0, 24'h000001);
    push_exp(1'b1, 24'hFFFFFE);
    send_bits(24'h000001, 0, 24);
    send_bits(24'hFFFFFE, 0, 24);
    check("t2_ready_low", 32'(ready_o), 32'd0);
    take_word("t2a");
    check("t2_valid_kept", 32'(rx_valid), 32'd1);
    take_word("t2b");
    check("t2_ready_back", 32'(ready_o), 32'd1);

    // Idle timeout after 10 bits.
    do_reset();
    send_bits(24'h0003FF, 0, 10);
    cyc(15);
    check("t3_no_err_yet", 32'(frame_err), 32'd0);
    cyc(1);
    check("t3_err_pulse", 32'(frame_err), 32'd1);
    cyc(1);
    check("t3_err_one_cycle", 32'(frame_err), 32'd0);
    push_exp(1'b0, 24'h5A5A5A);
    send_bits(24'h5A5A5A, 0, 24);
    take_word("t3");

    // MSB-first transmit with ready toggling.
    w         = 24'h800001;
    tx_data2  = w;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    idx       = 0;
    for (int c = 0; c < 100 && idx < 24; c++) begin
      ready2 = ~ready2;
      check("t4_dout_valid", 32'(dout_valid2), 32'd1);
      check("t4_dout", 32'(dout2), 32'(w[23-idx]));
      check("t4_tx_ready", 32'(tx_ready2), 32'd1);
      if (ready2) idx++;
      @(negedge clk);
    end
    ready2 = 1'b0;
    check("t4_bits_sent", 32'(idx), 32'd24);
    check("t4_done", 32'(dout_valid2), 32'd0);

    // Reset mid-word on both paths.
    do_reset();
    send_bits(24'hABCDEF, 0, 24);
    send_bits(24'h111111, 0, 12);
    tx_data  = 24'hC0FFEE;
    tx_valid = 1'b1;
    ready_tb = 1'b1;
    @(negedge clk);
    tx_data = 24'h000123;
    @(negedge clk);
    tx_valid = 1'b0;
    cyc(4);
    check("t5_pre_tx_ready", 32'(tx_ready), 32'd0);
    check("t5_pre_rx_valid", 32'(rx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("t5");
    cyc(1);
    rst_n    = 1'b1;
    ready_tb = 1'b0;
    cyc(1);
    check("t5_tx_idle", 32'(dout_valid), 32'd0);
    push_exp(1'b0, 24'h123456);
    send_bits(24'h123456, 0, 24);
    take_word("t5");

    // Loopback with random stalls.
    do_reset();
    lb   = 1'b1;
    ch   = 1'b0;
    recv = 0;
    ferr = 0;
    fork
      begin
        for (int k = 0; k < 64; k++) begin
          int n;
          n = 0;
          while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
          end
          r32      = $urandom;
          tx_data  = r32[DW-1:0];
          tx_valid = 1'b1;
          push_exp(ch, r32[DW-1:0]);
          ch = ~ch;
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
      begin
        for (int c = 0; c < 30000 && recv < 64; c++) begin
          en       = ($urandom_range(0, 7) != 0);
          go       = ($urandom_range(0, 3) != 0);
          rx_ready = ($urandom_range(0, 2) != 0);
          if (rx_valid && rx_ready && en) begin
            if (sb.size() == 0) begin
              check("lb_sb_empty", 32'(sb.size()), 32'd1);
            end else begin
              e = sb.pop_front();
              check("lb_data", 32'(rx_data), {8'd0, e[23:0]});
              check("lb_chan", 32'(rx_chan), {31'd0, e[24]});
            end
            recv++;
          end
          if (frame_err) ferr++;
          @(negedge clk);
        end
      end
    join
    en       = 1'b1;
    go       = 1'b0;
    lb       = 1'b0;
    rx_ready = 1'b0;
    check("lb_received", 32'(recv), 32'd64);
    check("lb_leftover", 32'(sb.size()), 32'd0);
    check("lb_frame_errs", 32'(ferr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_stream_bridge.md
# serial_stream_bridge

Parametrised bit-serial bridge between the serial pins and the multi-channel word datapath of the filter. The receive path assembles serial bits into DATA_WIDTH words tagged with a round-robin channel index and double-buffers them. The transmit path shifts parallel words out under a downstream ready. It adds channel interleaving, selectable bit order, receive double-buffering and a mid-word idle timeout to the single-channel LSB-first interface.

## Interface
- DATA_WIDTH, 24, bits per word
- NUM_CHANNELS, 2, words per frame; channel index wraps NUM_CHANNELS-1 -> 0
- MSB_FIRST, 0, 0: LSB sent/received first; 1: MSB first (both paths)
- IDLE_TIMEOUT, 64, cycles of i_din_valid low mid-word before the partial word is discarded; 0 disables
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low; one clock domain
- i_en  in  1  global enable; low freezes all state and forces o_ready=0; transmit shifting also stalls
- i_din  in  1  serial data in
- i_din_valid  in  1  i_din qualifier
- o_ready  out  1  bridge can accept a receive bit
- o_rx_data  out  DATA_WIDTH  assembled word
- o_rx_chan  out  CHAN_W  channel of o_rx_data; CHAN_W = max(1, $clog2(NUM_CHANNELS))
- o_rx_valid  out  1  o_rx_data/o_rx_chan valid
- i_rx_ready  in  1  datapath takes the word
- o_frame_err  out  1  one-cycle pulse on timeout discard
- i_tx_data  in  DATA_WIDTH  word to transmit
- i_tx_valid  in  1  i_tx_data valid
- o_tx_ready  out  1  transmit load register empty
- o_dout  out  1  serial data out
- o_dout_valid  out  1  o_dout carries a word bit
- i_ready  in  1  downstream accepts o_dout this cycle

## Operation
- Rx bit transfer: i_en & i_din_valid & o_ready at a rising edge. Bit goes into the shift register at the LSB or MSB end according to MSB_FIRST. The bit counter increments.
- On the DATA_WIDTH-th bit the completed word moves to the holding register with the current channel. Channel advances mod NUM_CHANNELS and the bit counter clears.
- Holding register handshake: o_rx_valid & i_rx_ready. Holding stays stable while unaccepted.
- o_ready = i_en & !(shift full & holding occupied). "Shift full" means DATA_WIDTH bits are captured and waiting.
  - With holding occupied, a new word can still fill the shift register. Transfer to holding happens on the edge holding is accepted.
- Idle timeout: counter runs while bit count != 0 and i_din_valid=0, and clears on any accepted bit. At IDLE_TIMEOUT:
  - bit count clears and the partial word is discarded
  - o_frame_err pulses for one cycle
  - channel index is unchanged
- Tx: a word loads into the load register on i_tx_valid & o_tx_ready. The shifter takes it from the load register when idle, same edge possible.
- Tx shifting: o_dout_valid is high while the shifter holds a word, and o_dout shows the current bit. The bit advances on o_dout_valid & i_ready & i_en.
  - After the DATA_WIDTH-th transfer the shifter reloads from the load register if it is full; otherwise o_dout_valid drops.
- Tx FSM states: IDLE, SHIFT. IDLE->SHIFT when the load register is full. SHIFT->IDLE after the last bit with no load pending.

## Timing
- Reset values:
  - o_ready=0 during reset, i_en-dependent after
  - o_rx_valid=0, o_rx_data=0, o_rx_chan=0
  - o_frame_err=0
  - o_tx_ready=1, o_dout_valid=0, o_dout=0
  - FSM IDLE, counters 0
- Rx latency: o_rx_valid high the cycle after the edge accepting the last bit, provided holding was free.
- Tx latency: o_dout_valid high the cycle after the load edge. Back-to-back words have zero idle cycles when the load register is pre-filled.
- Simultaneous holding accept and new word completion: the new word enters holding on that same edge and o_rx_valid stays high.
- Simultaneous timeout and accepted bit: the bit wins and there is no timeout.
- Reset mid-word discards all partial and held state, and the channel returns to 0.

## Structure
- Package serial_stream_pkg:
  - tx FSM state enum
  - CHAN_W and counter-width helper functions
- Sub-module serial_tx_lane: load register, shifter and FSM. Rx logic lives in the top.

## Test plan
- DATA_WIDTH=24, NUM_CHANNELS=2, MSB_FIRST=0: send 0xA5C3F1 LSB-first -> o_rx_data=0xA5C3F1, o_rx_chan=0, o_rx_valid high one cycle after the 24th bit.
- i_rx_ready=0, send 0x000001 then 0xFFFFFE -> o_ready low after the 48th bit. Then raise i_rx_ready -> words delivered in order with chan 0, 1, and o_ready returns high.
- IDLE_TIMEOUT=16: send 10 bits, hold i_din_valid low for 16 cycles -> o_frame_err pulses once. The next 24 bits give a clean word on chan 0.
- MSB_FIRST=1: tx 0x800001 with i_ready toggling every cycle -> bits 1, 22×0, 1, each emitted only on ready cycles. o_tx_ready stays high throughout.
- Assert i_rst_n low after 12 rx bits and mid tx word -> all outputs at reset values. A subsequent 0x123456 is received intact on chan 0.
- Loopback o_dout->i_din: 64 random words with random i_ready/i_rx_ready/i_en stalls -> all received in order, channels alternate 0, 1, and there are no frame errors.
